// File: rtl/fifo_rd_drain_if.sv
`default_nettype none
// ============================================================================
// fifo_rd_drain_if : FIFO read port plus valid/ready output stream bundle
// Rev 1.0
// ============================================================================
interface fifo_rd_drain_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_data_out,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_underflow,
        output fifo_data_out,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// fifo_rd_drain : FIFO read controller with a 2-entry valid/ready output buffer.
// Optional macro FIFO_RD_STATS_EN adds words_out / stall_cycles counters.
// Rev 1.0
// ============================================================================
module fifo_rd_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       rd_enable,
    input  wire logic       flush,
    fifo_rd_drain_if.master bus,
    output logic            underflow_err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]     words_out,
    output logic [15:0]     stall_cycles
`endif
);

    generate
        if (BUF_DEPTH != 2) begin : g_depth_check
            $error("fifo_rd_drain: BUF_DEPTH must be 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                r_state;
    logic [FIFO_WIDTH-1:0] r_head;
    logic [FIFO_WIDTH-1:0] r_tail;
    logic [1:0]            r_occ;
    logic                  r_infl;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic [2:0]            w_pending;

    // Words already owned (buffered + in flight) after this cycle's pop; keeping
    // this below 2 guarantees every issued read has a free slot when it lands.
    assign w_pop     = bus.m_valid && bus.m_ready;
    assign w_pending = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_rd_en   = (r_state == ST_ACTIVE) && rd_enable && !flush &&
                       !bus.fifo_empty && (w_pending < 3'd2);
    assign w_push    = r_infl && !bus.fifo_underflow && !flush;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = (r_occ != 2'd0);
    assign bus.m_data     = r_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_occ         <= 2'd0;
            r_infl        <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            underflow_err <= 1'b0;
        end else begin
            r_infl <= w_rd_en;
            if (r_infl && bus.fifo_underflow) begin
                underflow_err <= 1'b1;
            end

            // FLUSH lasts one cycle; every state leaves by the same rule.
            if (flush) begin
                r_state <= ST_FLUSH;
            end else if (rd_enable) begin
                r_state <= ST_ACTIVE;
            end else begin
                r_state <= ST_IDLE;
            end

            if (flush) begin
                r_occ <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_occ == 2'd0) begin
                            r_head <= bus.fifo_data_out;
                        end else begin
                            r_tail <= bus.fifo_data_out;
                        end
                        r_occ <= r_occ + 2'd1;
                    end
                    2'b01: begin
                        r_head <= r_tail;
                        r_occ  <= r_occ - 2'd1;
                    end
                    2'b11: begin
                        if (r_occ == 2'd1) begin
                            r_head <= bus.fifo_data_out;
                        end else begin
                            r_head <= r_tail;
                            r_tail <= bus.fifo_data_out;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_out    <= 16'd0;
            stall_cycles <= 16'd0;
        end else begin
            if (w_pop && (words_out != 16'hFFFF)) begin
                words_out <= words_out + 16'd1;
            end
            if (bus.m_valid && !bus.m_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_drain : directed + randomized bench with a queue-based reference
// Rev 1.0
// ============================================================================
module tb_fifo_rd_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_enable = 1'b0;
    logic flush = 1'b0;
    logic underflow_err;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] words_out;
    logic [15:0] stall_cycles;
`endif

    fifo_rd_drain_if #(.FIFO_WIDTH(16)) bus ();

    fifo_rd_drain #(.FIFO_WIDTH(16), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_enable     (rd_enable),
        .flush         (flush),
        .bus           (bus),
        .underflow_err (underflow_err)
`ifdef FIFO_RD_STATS_EN
        ,
        .words_out     (words_out),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: stream words owned by the block, plus the upstream FIFO contents.
    logic [15:0] bq[$];
    logic [15:0] tfq[$];
    logic [15:0] got[$];
    bit active_m = 1'b0;
    bit infl_m = 1'b0;
    bit err_m = 1'b0;
    bit exp_rd_en = 1'b0;
    bit force_empty = 1'b0;
    int words_m = 0;
    int stall_m = 0;
    int rd_pulses = 0;
    int first_rd = -1;
    int first_vld = -1;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_empty();
        bus.fifo_empty = force_empty || (tfq.size() == 0);
    endtask

    task automatic load(input logic [15:0] w);
        tfq.push_back(w);
        refresh_empty();
    endtask

    task automatic step();
        int pop_m;
        int pend;
        @(negedge clk);
        pop_m = (bq.size() > 0 && bus.m_ready) ? 1 : 0;
        pend = bq.size() + int'(infl_m) - pop_m;
        exp_rd_en = active_m && rd_enable && !flush && !bus.fifo_empty && (pend < 2);
        chk("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd_en));
        chk("m_valid", 32'(bus.m_valid), 32'(bq.size() > 0));
        if (bq.size() > 0) chk("m_data", 32'(bus.m_data), 32'(bq[0]));
        chk("underflow_err", 32'(underflow_err), 32'(err_m));
        if (bus.fifo_rd_en === 1'b1) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got.push_back(bus.m_data);

        @(posedge clk);
        if (!rst_n) begin
            bq.delete();
            infl_m = 1'b0;
            active_m = 1'b0;
            err_m = 1'b0;
            words_m = 0;
            stall_m = 0;
        end else begin
            if (pop_m == 1 && words_m < 65535) words_m++;
            if (bq.size() > 0 && !bus.m_ready && stall_m < 65535) stall_m++;
            if (infl_m && bus.fifo_underflow) err_m = 1'b1;
            if (flush) begin
                bq.delete();
            end else begin
                if (pop_m == 1) void'(bq.pop_front());
                if (infl_m && !bus.fifo_underflow) bq.push_back(bus.fifo_data_out);
            end
            infl_m = exp_rd_en;
            active_m = rd_enable && !flush;
        end
        #1;
        if (exp_rd_en && tfq.size() > 0) bus.fifo_data_out = tfq.pop_front();
        refresh_empty();
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        rd_enable = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;
        force_empty = 1'b0;
        tfq.delete();
        refresh_empty();
        step();
        step();
        chk("rst_m_data", 32'(bus.m_data), 32'h0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
        rst_n = 1'b1;
        got.delete();
        rd_pulses = 0;
        first_rd = -1;
        first_vld = -1;
        cyc = 0;
    endtask

    initial begin
        bus.fifo_data_out = 16'h0;
        bus.fifo_underflow = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_empty = 1'b1;

        // Empty FIFO while enabled: nothing read, nothing presented.
        do_reset();
        rd_enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("empty_rd_pulses", 32'(rd_pulses), 32'd0);
        chk("empty_no_valid", 32'(first_vld), 32'hFFFF_FFFF);

        // Three words, always ready: back-to-back reads and 2-cycle latency.
        do_reset();
        rd_enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) load(16'hA001 + 16'(i));
        for (int i = 0; i < 8; i++) step();
        chk("burst3_rd_pulses", 32'(rd_pulses), 32'd3);
        chk("burst3_latency", 32'(first_vld - first_rd), 32'd2);
        chk("burst3_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("burst3_data", 32'(got[i]), 32'hA001 + 32'(i));

        // Five words with back-pressure: only two reads until released.
        do_reset();
        rd_enable = 1'b1;
        for (int i = 0; i < 5; i++) load(16'hA001 + 16'(i));
        for (int i = 0; i < 8; i++) step();
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        chk("bp_head_hold", 32'(bus.m_data), 32'hA001);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_data", 32'(got[i]), 32'hA001 + 32'(i));

        // Flush with one word buffered and one in flight.
        do_reset();
        rd_enable = 1'b1;
        for (int i = 0; i < 6; i++) load(16'hB001 + 16'(i));
        for (int i = 0; i < 5; i++) step();
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid_drop", 32'(bus.m_valid), 32'h0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("flush_count", 32'(got.size()), 32'd4);
        if (got.size() >= 2) begin
            chk("flush_first", 32'(got[0]), 32'hB001);
            chk("flush_next", 32'(got[1]), 32'hB004);
        end

        // Underflow on the read-return cycle: word dropped, sticky flag.
        do_reset();
        rd_enable = 1'b1;
        bus.m_ready = 1'b1;
        load(16'hC001);
        load(16'hC002);
        step();
        step();
        bus.fifo_underflow = 1'b1;
        step();
        bus.fifo_underflow = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("uf_sticky", 32'(underflow_err), 32'h1);
        chk("uf_count", 32'(got.size()), 32'd1);
        if (got.size() >= 1) chk("uf_data", 32'(got[0]), 32'hC002);
        do_reset();
        chk("uf_cleared", 32'(underflow_err), 32'h0);

        // Empty flag toggling every cycle.
        rd_enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) load(16'hD001 + 16'(i));
        for (int i = 0; i < 20; i++) begin
            force_empty = (i % 2) == 0;
            refresh_empty();
            step();
        end
        force_empty = 1'b0;
        refresh_empty();
        for (int i = 0; i < 6; i++) step();
        chk("toggle_count", 32'(got.size()), 32'd6);

        // Randomized traffic against the reference.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && tfq.size() < 8) tfq.push_back(16'($urandom));
            rd_enable = ($urandom_range(0, 9) != 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            bus.fifo_underflow = ($urandom_range(0, 59) == 0);
            force_empty = ($urandom_range(0, 5) == 0);
            refresh_empty();
            step();
        end
        flush = 1'b0;
        bus.fifo_underflow = 1'b0;
        force_empty = 1'b0;

`ifdef FIFO_RD_STATS_EN
        do_reset();
        chk("stats_rst_words", 32'(words_out), 32'd0);
        chk("stats_rst_stall", 32'(stall_cycles), 32'd0);
        rd_enable = 1'b1;
        for (int i = 0; i < 4; i++) load(16'hE001 + 16'(i));
        for (int k = 0; k < 10 && bq.size() == 0; k++) step();
        for (int i = 0; i < 3; i++) step();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("stats_words", 32'(words_out), 32'(words_m));
        chk("stats_words_4", 32'(words_out), 32'd4);
        chk("stats_stall_3", 32'(stall_cycles), 32'd3);
        do_reset();
        chk("stats_clr_words", 32'(words_out), 32'd0);
        chk("stats_clr_stall", 32'(stall_cycles), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
